// File: rtl/vga_frame_monitor.sv
// Receive-side checker for the TinyVGA bus: sync recovery, line/frame length checks, lock FSM, per-frame CRC.
// Define VGA_MON_CRC_EN to build the active-pixel CRC; otherwise frame_crc reads 16'h0000.
module vga_frame_monitor #(
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned H_START  = 144,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_START  = 35,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_in,
    input  logic        err_clr,
    output logic        locked,
    output logic        frame_done,
    output logic [9:0]  h_len,
    output logic [9:0]  v_len,
    output logic [15:0] frame_crc,
    output logic        h_err,
    output logic        v_err
);

    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_SYNCING = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    logic [7:0]       vq_q, vp_q;
    logic             hs_fall, vs_fall;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] h_len_q, h_len_d, v_len_q, v_len_d;
    logic [CNT_W:0]   h_meas, v_meas;
    logic             h_len_ok, v_len_ok, pix_active;
    state_e           state_q, state_d;
    logic             line_bad_q, line_bad_d, skip_q, skip_d, line_bad_now;
    logic             locked_q, frame_done_q, frame_done_d;
    logic             h_err_q, h_err_d, v_err_q, v_err_d, h_err_set, v_err_set;

    assign hs_fall  = vp_q[7] & ~vq_q[7];
    assign vs_fall  = vp_q[3] & ~vq_q[3];
    assign h_meas   = (CNT_W+1)'(h_cnt_q) + (CNT_W+1)'(1);
    assign v_meas   = (CNT_W+1)'(v_cnt_q) + (CNT_W+1)'(1);
    assign h_len_ok = (h_meas == (CNT_W+1)'(H_TOTAL));
    assign v_len_ok = (v_meas == (CNT_W+1)'(V_TOTAL));

    // vp_q carries the pixel whose index after the sync fall equals h_cnt_q / v_cnt_q
    assign pix_active = (h_cnt_q >= CNT_W'(H_START)) && (h_cnt_q <= CNT_W'(H_START + H_ACTIVE - 1)) &&
                        (v_cnt_q >= CNT_W'(V_START)) && (v_cnt_q <= CNT_W'(V_START + V_ACTIVE - 1));

    // Line and frame counters with length capture
    always_comb begin
        h_cnt_d = h_cnt_q;
        h_len_d = h_len_q;
        v_cnt_d = v_cnt_q;
        v_len_d = v_len_q;
        if (hs_fall) begin
            h_len_d = h_meas[CNT_W-1:0];
            h_cnt_d = '0;
        end else if (h_cnt_q != CNT_MAX) begin
            h_cnt_d = h_cnt_q + CNT_W'(1);
        end
        if (vs_fall) begin
            v_len_d = v_meas[CNT_W-1:0];
            v_cnt_d = '0;
        end else if (hs_fall && (v_cnt_q != CNT_MAX)) begin
            v_cnt_d = v_cnt_q + CNT_W'(1);
        end
    end

    // Lock FSM: next state, lock qualification and error events
    always_comb begin
        state_d      = state_q;
        line_bad_d   = line_bad_q;
        skip_d       = skip_q;
        line_bad_now = line_bad_q;
        frame_done_d = 1'b0;
        h_err_set    = 1'b0;
        v_err_set    = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (vs_fall) begin
                    state_d    = ST_SYNCING;
                    line_bad_d = 1'b0;
                    skip_d     = 1'b1;
                end
            end
            ST_SYNCING: begin
                if (hs_fall) begin
                    skip_d = 1'b0;
                    if (!skip_q && !h_len_ok) line_bad_now = 1'b1;
                end
                line_bad_d = line_bad_now;
                if (vs_fall) begin
                    if (!line_bad_now && v_len_ok) state_d = ST_LOCKED;
                    line_bad_d = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (hs_fall && !h_len_ok) begin
                    // the broken frame must not count as the clean frame needed to relock
                    h_err_set  = 1'b1;
                    state_d    = ST_SYNCING;
                    line_bad_d = 1'b1;
                    skip_d     = 1'b1;
                end else if (h_cnt_q == CNT_MAX) begin
                    h_err_set = 1'b1;
                    state_d   = ST_SEARCH;
                end else if (vs_fall) begin
                    if (v_len_ok) begin
                        frame_done_d = 1'b1;
                    end else begin
                        v_err_set  = 1'b1;
                        state_d    = ST_SYNCING;
                        line_bad_d = 1'b0;
                        skip_d     = 1'b1;
                    end
                end
            end
            default: state_d = ST_SEARCH;
        endcase
        h_err_d = h_err_set | (h_err_q & ~err_clr);
        v_err_d = v_err_set | (v_err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vq_q         <= 8'hFF;
            vp_q         <= 8'hFF;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            h_len_q      <= '0;
            v_len_q      <= '0;
            state_q      <= ST_SEARCH;
            line_bad_q   <= 1'b0;
            skip_q       <= 1'b0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            h_err_q      <= 1'b0;
            v_err_q      <= 1'b0;
        end else begin
            vq_q         <= vga_in;
            vp_q         <= vq_q;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            h_len_q      <= h_len_d;
            v_len_q      <= v_len_d;
            state_q      <= state_d;
            line_bad_q   <= line_bad_d;
            skip_q       <= skip_d;
            locked_q     <= (state_d == ST_LOCKED);
            frame_done_q <= frame_done_d;
            h_err_q      <= h_err_d;
            v_err_q      <= v_err_d;
        end
    end

    assign locked     = locked_q;
    assign frame_done = frame_done_q;
    assign h_len      = h_len_q;
    assign v_len      = v_len_q;
    assign h_err      = h_err_q;
    assign v_err      = v_err_q;

`ifdef VGA_MON_CRC_EN
    logic [15:0] crc_q, crc_d, frame_crc_q, frame_crc_d;

    // CRC-16-CCITT, six pixel bits per clock, MSB first
    function automatic logic [15:0] crc6_step(input logic [15:0] crc, input logic [5:0] d);
        logic [15:0] r;
        r = crc;
        for (int i = 5; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        crc_d       = crc_q;
        frame_crc_d = frame_crc_q;
        if (vs_fall) begin
            frame_crc_d = crc_q;
            crc_d       = 16'hFFFF;
        end else if (pix_active) begin
            crc_d = crc6_step(crc_q, {vp_q[0], vp_q[4], vp_q[1], vp_q[5], vp_q[2], vp_q[6]});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q       <= 16'hFFFF;
            frame_crc_q <= 16'h0000;
        end else begin
            crc_q       <= crc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    logic unused_pix;
    assign unused_pix = ^{vp_q[6:4], vp_q[2:0], pix_active};
    assign frame_crc  = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor on a scaled-down raster; frame_done results are checked by a queue scoreboard.
module tb_vga_frame_monitor;

    localparam int HT = 40, VT = 20, HSW = 4, VSW = 2;
    localparam int HS = 8, HA = 24, VS = 4, VA = 12;

    typedef struct packed {
        logic [9:0]  vl;
        logic [9:0]  hl;
        logic [15:0] crc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  vga_in;
    logic        err_clr;
    logic        locked, frame_done, h_err, v_err;
    logic [9:0]  h_len, v_len;
    logic [15:0] frame_crc;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vga_frame_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vga_in(vga_in), .err_clr(err_clr),
        .locked(locked), .frame_done(frame_done), .h_len(h_len), .v_len(v_len),
        .frame_crc(frame_crc), .h_err(h_err), .v_err(v_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_bit(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        crc = crc << 1;
        if (fb) crc = crc ^ 16'h1021;
        return crc;
    endfunction

    function automatic logic [5:0] color(input int x, input int y, input int pat, input int mx, input int my);
        logic [5:0] c;
        c = (pat == 0) ? 6'd0 : 6'((x * 3 + y * 5) ^ (x >> 2));
        if (x == mx && y == my) c = ~c;
        return c;
    endfunction

    // c = {R1,R0,G1,G0,B1,B0}; bus = {hs,B0,G0,R0,vs,B1,G1,R1}
    task automatic put(input int x, input int y, input logic [5:0] c);
        @(negedge clk);
        vga_in = {(x >= HSW), c[0], c[2], c[4], (y >= VSW), c[1], c[3], c[5]};
    endtask

    task automatic frame(input int lines, input int short_line, input int pat,
                         input int mx, input int my, input bit expect_done);
        logic [15:0] crc;
        exp_t        e;
        int          len;
        crc = 16'hFFFF;
        for (int y = 0; y < lines; y++) begin
            len = (y == short_line) ? HT - 1 : HT;
            for (int x = 0; x < len; x++) begin
                if (y >= VS && y < VS + VA && x >= HS && x < HS + HA) begin
                    logic [5:0] c;
                    c = color(x, y, pat, mx, my);
                    for (int b = 5; b >= 0; b--) crc = crc_bit(crc, c[b]);
                end
            end
        end
        e.vl = 10'(lines);
        e.hl = 10'(HT);
`ifdef VGA_MON_CRC_EN
        e.crc = crc;
`else
        e.crc = 16'h0000;
`endif
        if (expect_done) exp_q.push_back(e);
        for (int y = 0; y < lines; y++) begin
            len = (y == short_line) ? HT - 1 : HT;
            for (int x = 0; x < len; x++) put(x, y, color(x, y, pat, mx, my));
        end
    endtask

    task automatic sync_pulse(input int n_high);
        for (int i = 0; i < HSW; i++) put(0, 0, 6'd0);
        for (int i = 0; i < n_high; i++) put(HSW, VSW, 6'd0);
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_frame_done: got 1, expected 0 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_v_len", 32'(v_len), 32'(e.vl));
                    chk("done_h_len", 32'(h_len), 32'(e.hl));
                    chk("done_frame_crc", 32'(frame_crc), 32'(e.crc));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        vga_in = 8'hFF;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_h_len", 32'(h_len), 0);
        chk("rst_v_len", 32'(v_len), 0);
        chk("rst_frame_crc", 32'(frame_crc), 0);
        chk("rst_h_err", 32'(h_err), 0);
        chk("rst_v_err", 32'(v_err), 0);
        rst_n = 1'b1;

        // acquisition: lock at 2nd vsync fall, first frame_done at 3rd
        frame(VT, -1, 0, -1, -1, 1'b0);
        chk("acq_locked_after_1st_fall", 32'(locked), 0);
        frame(VT, -1, 0, -1, -1, 1'b1);
        chk("acq_locked_after_2nd_fall", 32'(locked), 1);
        chk("acq_h_len", 32'(h_len), 32'(HT));
        chk("acq_v_len", 32'(v_len), 32'(VT));
        chk("acq_h_err", 32'(h_err), 0);
        chk("acq_v_err", 32'(v_err), 0);

        // fixed pattern, then one active pixel changed, then one porch pixel changed
        frame(VT, -1, 1, -1, -1, 1'b1);
        frame(VT, -1, 1, -1, -1, 1'b1);
        frame(VT, -1, 1, -1, -1, 1'b1);
        frame(VT, -1, 1, HS + 5, VS + 3, 1'b1);
        frame(VT, -1, 1, HS - 2, VS + 1, 1'b1);

        // short line while locked
        fork
            frame(VT, 7, 1, -1, -1, 1'b0);
            begin
                repeat (7 * HT + HT - 1 + 5) @(negedge clk);
                chk("short_h_len", 32'(h_len), 32'(HT - 1));
                chk("short_h_err", 32'(h_err), 1);
                chk("short_locked", 32'(locked), 0);
            end
        join
        frame(VT, -1, 1, -1, -1, 1'b0);
        chk("short_relock_wait", 32'(locked), 0);
        chk("short_h_err_sticky", 32'(h_err), 1);
        fork
            frame(VT, -1, 1, -1, -1, 1'b1);
            begin
                repeat (100) @(negedge clk);
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                chk("err_clr_h_err", 32'(h_err), 0);
            end
        join
        chk("short_relocked", 32'(locked), 1);

        // short frame while locked
        frame(VT - 1, -1, 0, -1, -1, 1'b0);
        frame(VT, -1, 0, -1, -1, 1'b0);
        chk("vshort_v_err", 32'(v_err), 1);
        chk("vshort_locked", 32'(locked), 0);
        chk("vshort_v_len", 32'(v_len), 32'(VT - 1));
        frame(VT, -1, 0, -1, -1, 1'b1);
        chk("vshort_relocked", 32'(locked), 1);

        // hsync lost while locked
        sync_pulse(1100);
        chk("lost_h_err", 32'(h_err), 1);
        chk("lost_locked", 32'(locked), 0);
        chk("lost_v_err_sticky", 32'(v_err), 1);
        frame(VT, -1, 0, -1, -1, 1'b0);
        chk("lost_after_1st_fall", 32'(locked), 0);
        frame(VT, -1, 0, -1, -1, 1'b1);
        chk("lost_after_2nd_fall", 32'(locked), 1);

        // one-cycle reset mid-frame while locked
        fork
            frame(VT, -1, 1, -1, -1, 1'b0);
            begin
                repeat (5 * HT + 20) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                chk("mid_rst_locked", 32'(locked), 0);
                chk("mid_rst_frame_done", 32'(frame_done), 0);
                chk("mid_rst_h_len", 32'(h_len), 0);
                chk("mid_rst_v_len", 32'(v_len), 0);
                chk("mid_rst_frame_crc", 32'(frame_crc), 0);
                chk("mid_rst_h_err", 32'(h_err), 0);
                chk("mid_rst_v_err", 32'(v_err), 0);
                rst_n = 1'b1;
            end
        join
        frame(VT, -1, 1, -1, -1, 1'b0);
        chk("rst_after_1st_fall", 32'(locked), 0);
        frame(VT, -1, 1, -1, -1, 1'b1);
        chk("rst_after_2nd_fall", 32'(locked), 1);

        sync_pulse(20);
        chk("missing_frame_done", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
